// File: rtl/pc_fetch_unit.sv
// PC register and IDLE/RUN/DONE fetch sequencer; optional taken-branch counter under BRANCH_COUNT_EN.
// Next-PC latency one cycle, LUT pointer combinational; no backpressure, one instruction per RUN cycle.
module pc_fetch_unit #(
  parameter int              PC_W     = 10,
  parameter int              LUT_AW   = 5,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Halt,
  input  logic              BranchEn,
  input  logic              BranchCond,
  input  logic [LUT_AW-1:0] BranchPtr,
  output logic [LUT_AW-1:0] LutAddr,
  input  logic [PC_W-1:0]   Target,
  output logic [PC_W-1:0]   PC,
  output logic              Running,
  output logic              Done,
  output logic [15:0]       TakenCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Halt outranks a branch in the same instruction; increment wraps silently.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = START_PC;
        end
      end
      RUN: begin
        if (Halt) begin
          state_d = DONE;
        end else if (BranchEn && BranchCond) begin
          pc_d = Target;
        end else begin
          pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_PC;
      end
    endcase
  end

  assign LutAddr = BranchPtr;
  assign PC      = pc_q;
  assign Running = (state_q == RUN);
  assign Done    = (state_q == DONE);

`ifdef BRANCH_COUNT_EN
  logic [15:0] taken_cnt_q;
  logic        branch_taken;
  logic        run_restart;

  assign branch_taken = (state_q == RUN) && !Halt && BranchEn && BranchCond;
  assign run_restart  = (state_q != RUN) && Start;

  // Saturating so a long-running loop never reports a small wrapped count.
  always_ff @(posedge Clk) begin
    if (Reset || run_restart) begin
      taken_cnt_q <= 16'h0000;
    end else if (branch_taken && (taken_cnt_q != 16'hFFFF)) begin
      taken_cnt_q <= taken_cnt_q + 16'h0001;
    end
  end

  assign TakenCount = taken_cnt_q;
`else
  assign TakenCount = 16'h0000;
`endif

endmodule
